// File: rtl/ddr_ch_arbiter.sv
// ddr_ch_arbiter: NUM_CH-channel DDR burst arbiter, fixed-priority or round-robin.
// Optional per-burst watchdog is compiled in when ARB_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module ddr_ch_arbiter #(
    parameter int NUM_CH        = 4,
    parameter int ADDR_WIDTH    = 30,
    parameter int MEM_DATA_BITS = 512,
    parameter int ARB_MODE      = 1,
    parameter int TIMEOUT_CYC   = 4096,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_CH-1:0]               ch_req_i,
    input  logic [NUM_CH-1:0]               ch_wr_i,
    input  logic [NUM_CH*8-1:0]             ch_len_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]    ch_addr_i,
    input  logic [NUM_CH*MEM_DATA_BITS-1:0] ch_wr_data_i,
    output logic [NUM_CH-1:0]               ch_wr_data_req_o,
    output logic [NUM_CH-1:0]               ch_rd_data_valid_o,
    output logic [MEM_DATA_BITS-1:0]        ch_rd_data_o,
    output logic [NUM_CH-1:0]               ch_finish_o,
    output logic                            burst_wr_req_o,
    output logic                            burst_rd_req_o,
    output logic [7:0]                      burst_len_o,
    output logic [ADDR_WIDTH-1:0]           burst_addr_o,
    input  logic                            burst_wr_data_req_i,
    output logic [MEM_DATA_BITS-1:0]        burst_wr_data_o,
    input  logic                            burst_rd_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0]        burst_rd_data_i,
    input  logic                            burst_wr_finish_i,
    input  logic                            burst_rd_finish_i,
    output logic [CH_W-1:0]                 grant_o,
    output logic                            busy_o,
    output logic                            timeout_o,
    output logic                            err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CH_W-1:0]          grant_q, grant_d;
    logic [CH_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                     wr_q, wr_d;
    logic [7:0]               len_q, len_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;

    logic [CH_W-1:0]          win_idx;
    logic                     win_vld;
    logic                     win_wr;
    logic [7:0]               win_len;
    logic [ADDR_WIDTH-1:0]    win_addr;
    logic [MEM_DATA_BITS-1:0] wr_data_sel;
    logic                     fin_match;
    logic                     wd_hit;
    logic                     in_busy;

    // Round robin: lowest requester at/after rr_ptr, else lowest overall.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req_i[i]) begin
                win_vld = 1'b1;
                win_idx = CH_W'(i);
            end
        end
        if (ARB_MODE != 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (ch_req_i[i] && (CH_W'(i) >= rr_ptr_q)) begin
                    win_idx = CH_W'(i);
                end
            end
        end
    end

    always_comb begin
        win_wr      = 1'b0;
        win_len     = '0;
        win_addr    = '0;
        wr_data_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_idx == CH_W'(i)) begin
                win_wr   = ch_wr_i[i];
                win_len  = ch_len_i[i*8 +: 8];
                win_addr = ch_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (grant_q == CH_W'(i)) begin
                wr_data_sel = ch_wr_data_i[i*MEM_DATA_BITS +: MEM_DATA_BITS];
            end
        end
    end

    assign fin_match = wr_q ? burst_wr_finish_i : burst_rd_finish_i;
    assign in_busy   = (state_q == BUSY);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (|ch_req_i) state_d = ARB;
            ARB: begin
                if (!win_vld) state_d = IDLE;
                else if (win_len == 8'd0) state_d = DONE;
                else state_d = BUSY;
            end
            BUSY: if (fin_match || wd_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        wr_d     = wr_q;
        len_d    = len_q;
        addr_d   = addr_q;
        if (state_q == ARB && win_vld) begin
            grant_d  = win_idx;
            wr_d     = win_wr;
            len_d    = win_len;
            addr_d   = win_addr;
            rr_ptr_d = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_q     <= 1'b0;
            len_q    <= '0;
            addr_q   <= '0;
        end else begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_q     <= wr_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
    logic        err_q, err_d;

    // A real finish in the same cycle wins over the watchdog.
    assign wd_hit = in_busy && !fin_match && (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = wd_hit;
        err_d     = err_q | wd_hit;
        if (state_q == ARB) wd_cnt_d = '0;
        else if (in_busy) wd_cnt_d = wd_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign timeout_o = timeout_q;
    assign err_o     = err_q;
`else
    assign wd_hit    = 1'b0;
    assign timeout_o = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_comb begin
        ch_wr_data_req_o   = '0;
        ch_rd_data_valid_o = '0;
        ch_finish_o        = '0;
        burst_wr_req_o     = in_busy & wr_q;
        burst_rd_req_o     = in_busy & ~wr_q;
        burst_wr_data_o    = in_busy ? wr_data_sel : '0;
        ch_rd_data_o       = in_busy ? burst_rd_data_i : '0;
        if (in_busy) begin
            ch_wr_data_req_o[grant_q]   = burst_wr_data_req_i;
            ch_rd_data_valid_o[grant_q] = burst_rd_data_valid_i;
        end
        if (state_q == DONE) ch_finish_o[grant_q] = 1'b1;
    end

    assign burst_len_o  = len_q;
    assign burst_addr_o = addr_q;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/ddr_ch_arbiter.md
# ddr_ch_arbiter

Parametrised N-channel DDR burst arbiter in the ui_clk domain. It sits between the per-stream vin/vout controllers and the DDR burst engine, and generalises the fixed 2-write/2-read channel pairing to NUM_CH mixed-direction channels. It adds selectable fixed-priority or round-robin arbitration, immediate completion of zero-length requests, and an optional per-burst watchdog.

## Interface
- NUM_CH, 4: number of requester channels (2..8); CH_W = clog2(NUM_CH).
- ADDR_WIDTH, 30: DDR burst address width.
- MEM_DATA_BITS, 512: DDR user data width.
- ARB_MODE, 1: 0 = fixed priority (ch0 highest), 1 = round robin.
- TIMEOUT_CYC, 4096: watchdog limit in clk_i cycles (used only with the macro).

Ports:
- clk_i  in  1  DDR user clock (ui_clk); the block's only clock.
- rst_i  in  1  reset; synchronous, active-high.
- ch_req_i  in  NUM_CH  per-channel request level.
- ch_wr_i  in  NUM_CH  direction: 1 = write, 0 = read.
- ch_len_i  in  NUM_CH*8  burst length in beats, 0..255.
- ch_addr_i  in  NUM_CH*ADDR_WIDTH  burst start address.
- ch_wr_data_i  in  NUM_CH*MEM_DATA_BITS  per-channel write data.
- ch_wr_data_req_o  out  NUM_CH  write-data pop, gated to the granted channel.
- ch_rd_data_valid_o  out  NUM_CH  read-data valid, gated to the granted channel.
- ch_rd_data_o  out  MEM_DATA_BITS  read data, broadcast to all channels.
- ch_finish_o  out  NUM_CH  one-cycle completion pulse.
- burst_wr_req_o / burst_rd_req_o  out  1  command level to the burst engine.
- burst_len_o  out  8; burst_addr_o  out  ADDR_WIDTH  latched command fields.
- burst_wr_data_req_i  in  1; burst_wr_data_o  out  MEM_DATA_BITS.
- burst_rd_data_valid_i  in  1; burst_rd_data_i  in  MEM_DATA_BITS.
- burst_wr_finish_i / burst_rd_finish_i  in  1  burst completion pulses.
- grant_o  out  CH_W  current or last grant index.
- busy_o  out  1  high in any state other than IDLE.
- timeout_o  out  1  watchdog pulse.
- err_o  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, ARB, BUSY, DONE.
- IDLE: if any ch_req_i bit is high, go to ARB.
- ARB (1 cycle):
  - Select the winner and register grant_o, direction, len and addr.
  - If the latched len is 0, go to DONE without issuing a command.
  - Otherwise go to BUSY.
- Fixed priority: the lowest requesting index wins.
- Round robin: search starts at rr_ptr; rr_ptr = winner+1, wrapping NUM_CH-1 to 0.
- BUSY:
  - burst_wr_req_o or burst_rd_req_o is held high, matching the latched direction.
  - Leave BUSY on the finish pulse that matches the direction; a finish of the opposite direction is ignored.
  - ch_wr_data_req_o[g] = burst_wr_data_req_i, combinational.
  - burst_wr_data_o = ch_wr_data_i slice g, combinational mux.
  - ch_rd_data_valid_o[g] = burst_rd_data_valid_i; ch_rd_data_o = burst_rd_data_i.
  - Bits for non-granted channels are 0.
- DONE (1 cycle): pulse ch_finish_o[g], drop the burst request, return to IDLE.
- Requester rule: hold ch_req_i and the command fields stable until ch_finish_o, then drop ch_req_i the next cycle. A req still high in IDLE is treated as a new request.
- A channel that drops ch_req_i before it is granted is simply not selected.
- Reset mid-burst: immediate return to IDLE. The burst engine must be reset by the same rst_i.

## Timing
- Reset values: every output is 0, rr_ptr = 0, FSM in IDLE.
- ch_req_i rises at cycle T: ARB at T+1, burst request high at T+2.
- Matching finish at F: ch_finish_o at F+1, burst request low at F+1, IDLE at F+2. Earliest next burst request is F+4.
- Zero-length request: ch_finish_o at T+2; no burst request is ever asserted.
- Data paths add zero cycles of latency.
- Command fields are registered in ARB and stay stable throughout BUSY.

## Configuration
- ARB_WATCHDOG_EN defined:
  - A 16-bit counter clears in ARB and increments each BUSY cycle.
  - On reaching TIMEOUT_CYC, go to DONE (ch_finish_o[g] pulses) and pulse timeout_o.
  - err_o sets and stays set until rst_i.
- ARB_WATCHDOG_EN undefined: no counter; timeout_o and err_o are tied to 0; BUSY waits indefinitely.

## Test plan
- ARB_MODE=0, ch1 and ch3 request writes (len 16) in the same cycle -> ch1 is granted first, burst_wr_req_o rises two cycles after the requests; ch3 is served after ch1's ch_finish_o.
- ARB_MODE=1, all four channels hold reads continuously -> grant order 0,1,2,3,0; ch_rd_data_valid_o is only ever asserted for the granted channel.
- Write of len 128 on ch2 -> burst_wr_data_o equals ch2's data on every burst_wr_data_req_i; ch_finish_o[2] is asserted exactly one cycle after burst_wr_finish_i.
- ch0 read with len 0 -> ch_finish_o[0] two cycles after the request; burst_rd_req_o stays 0.
- Stray burst_rd_finish_i during a write burst -> ignored, state stays BUSY; rst_i asserted mid-burst -> all outputs 0 on the next cycle.
- With ARB_WATCHDOG_EN and TIMEOUT_CYC=64, never assert finish -> timeout_o pulses and ch_finish_o[g] fires; err_o stays 1 until reset.
